ifetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Owns the fetch PC and issues in-order reads to instruction memory over a req/gnt + rvalid interface.
- Buffers returned instructions, each tagged with its PC, in a small FIFO.
- Hands instructions to decode with valid/ready. A branch redirect (pcsrc path) flushes everything in flight.

---
 rtl/ifetch_pkg.sv | 16 +
 rtl/ifetch_fifo.sv | 61 ++++++
 rtl/ifetch_unit.sv | 108 ++++++++++
 tb/tb_ifetch_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared widths, constants and the buffered-instruction entry type for the
// instruction-fetch stage.
package ifetch_pkg;

  localparam int ADDR_W      = 10;
  localparam int INSTR_W     = 16;
  localparam int PC_STEP     = 2;
  localparam int FETCH_DEPTH = 2;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from the entry
// registers so pushed data is visible the cycle after the push.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty && !flush;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns fetch_pc, issues credit-limited in-order reads, tags
// responses with their PC and discards responses made stale by a redirect.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int                DEPTH    = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ifetch_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               dec_ready,
  output logic [ADDR_W-1:0]  pc_out
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     live;
  logic [CW-1:0]     drop;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     tag_count;
  logic [CW+1:0]     occ;
  logic              has_credit;
  logic              accept;
  logic              rsp_keep;
  logic              rsp_drop;
  logic              fifo_empty;
  logic              tag_empty;
  logic [ADDR_W-1:0] tag_head;
  fetch_entry_t      fifo_din;
  fetch_entry_t      fifo_head;

  // Every buffered entry, outstanding live request and pending discard holds a slot.
  assign occ        = (CW+2)'(fifo_count) + (CW+2)'(live) + (CW+2)'(drop);
  assign has_credit = occ < (CW+2)'(DEPTH);
  assign imem_req   = !reset && has_credit && !redirect;
  assign imem_addr  = fetch_pc;
  assign pc_out     = fetch_pc;
  assign accept     = imem_req && imem_gnt;
  assign rsp_drop   = imem_rvalid && (drop != '0);
  assign rsp_keep   = imem_rvalid && (drop == '0);

  assign fifo_din   = '{instr: imem_rdata, pc: tag_head};
  assign dec_valid  = !fifo_empty;
  assign dec_instr  = fifo_head.instr;
  assign dec_pc     = fifo_head.pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      live     <= '0;
      drop     <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~ADDR_W'(1);
      live     <= '0;
      // An rvalid in the redirect cycle retires one of the old outstanding requests.
      drop     <= drop + live + CW'(accept) - CW'(imem_rvalid);
    end else begin
      if (accept) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      live <= live + CW'(accept) - CW'(rsp_keep);
      drop <= drop - CW'(rsp_drop);
    end
  end

  ifetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_keep && !redirect),
    .din   (fifo_din),
    .pop   (dec_valid && dec_ready && !redirect),
    .flush (redirect),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Tags of live requests only; tags of discarded requests go with the flush.
  ifetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept && !redirect),
    .din   (fetch_pc),
    .pop   (rsp_keep && !redirect),
    .flush (redirect),
    .dout  (tag_head),
    .count (tag_count),
    .empty (tag_empty)
  );

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_rvalid && live == '0 && drop == '0));
      assert (tag_count == live);
      assert (!(rsp_keep && tag_empty));
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus random traffic, compared
// against a queue-based model of the fetch stage and its memory.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  localparam int DEPTH = 2;

  logic               clk;
  logic               reset;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dec_valid;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc;
  logic               dec_ready;
  logic [ADDR_W-1:0]  pc_out;

  ifetch_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready),
    .pc_out      (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outstanding memory requests (in order) and the decode-side buffer.
  typedef struct {
    logic [ADDR_W-1:0] pc;
    int                due;
    bit                stale;
  } pend_t;

  typedef struct {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } ent_t;

  pend_t             pend[$];
  ent_t              fq[$];
  logic [ADDR_W-1:0] m_pc;
  int                cyc;
  int                checks;
  int                errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    fq.delete();
    m_pc = '0;
  endtask

  // Called at a negedge: drive one cycle of inputs, check outputs, advance model.
  task automatic step(input bit r, input logic [ADDR_W-1:0] rpc, input bit g,
                      input bit d, input int lat);
    bit                 v;
    bit                 req;
    bit                 pop_ok;
    logic [INSTR_W-1:0] rd;
    pend_t              h;
    v  = (pend.size() > 0) && (pend[0].due <= cyc);
    rd = v ? (INSTR_W'(pend[0].pc) ^ 16'hA5A5) : INSTR_W'($urandom);
    redirect    = r;
    redirect_pc = rpc;
    imem_gnt    = g;
    dec_ready   = d;
    imem_rvalid = v;
    imem_rdata  = rd;
    #1;
    req = ((fq.size() + pend.size()) < DEPTH) && !r;
    check("imem_req", imem_req, req);
    check("imem_addr", imem_addr, m_pc);
    check("pc_out", pc_out, m_pc);
    check("dec_valid", dec_valid, fq.size() > 0);
    if (fq.size() > 0) begin
      check("dec_pc", dec_pc, fq[0].pc);
      check("dec_instr", dec_instr, fq[0].instr);
    end
    pop_ok = !r && d && (fq.size() > 0);
    if (pop_ok) void'(fq.pop_front());
    if (v) begin
      h = pend.pop_front();
      if (!r && !h.stale) fq.push_back('{rd, h.pc});
    end
    if (r) begin
      fq.delete();
      for (int i = 0; i < pend.size(); i++) pend[i].stale = 1'b1;
      m_pc = rpc & 10'h3FE;
    end else if (req && g) begin
      pend.push_back('{m_pc, cyc + lat, 1'b0});
      m_pc = m_pc + ADDR_W'(2);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Called at a negedge: reset asserted asynchronously mid-cycle.
  task automatic do_reset();
    #2;
    reset       = 1'b1;
    redirect    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    dec_ready   = 1'b0;
    #1;
    check("rst_dec_valid", dec_valid, 1'b0);
    check("rst_dec_instr", dec_instr, 16'h0000);
    check("rst_dec_pc", dec_pc, 10'h000);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_pc_out", pc_out, 10'h000);
    check("rst_imem_addr", imem_addr, 10'h000);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] saved;
    int n;
    checks = 0; errors = 0; cyc = 0;
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Streaming with single-cycle memory.
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b1, 1);

    // Decode stall fills the buffer and stops fetching at 4.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, 1);
    check("stall_pc_hold", pc_out, 10'h004);
    check("stall_req_low", imem_req, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1, 1);

    // Latency 3, two live requests, redirect to 0x100.
    do_reset();
    step(1'b0, '0, 1'b1, 1'b1, 3);
    step(1'b0, '0, 1'b1, 1'b1, 3);
    step(1'b1, 10'h100, 1'b1, 1'b1, 3);
    n = 0;
    while (!dec_valid && n < 20) begin
      step(1'b0, '0, 1'b1, 1'b1, 3);
      n++;
    end
    check("redirect_wait", n < 20, 1'b1);
    check("first_pc_after_redirect", dec_pc, 10'h100);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1, 3);

    // Redirect to odd 0x3FD while 0x010 is being granted; fetch wraps past 0x3FE.
    do_reset();
    n = 0;
    while (!(imem_addr == 10'h010 && imem_req) && n < 40) begin
      step(1'b0, '0, 1'b1, 1'b1, 1);
      n++;
    end
    check("reach_0x010", imem_addr, 10'h010);
    step(1'b1, 10'h3FD, 1'b1, 1'b1, 1);
    check("redirect_align", pc_out, 10'h3FC);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1, 1);

    // Grant withheld: request and address stay put.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b0, 1'b1, 1);
    saved = imem_addr;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, 1'b1, 1);
      check("gnt_low_addr", imem_addr, saved);
      check("gnt_low_req", imem_req, 1'b1);
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1, 1);

    // Reset mid-stream with buffered data and a live request.
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 3);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b1, 1);

    // Random traffic with occasional redirects and resets.
    for (int i = 0; i < 1500; i++) begin
      if (i % 500 == 499) do_reset();
      else step($urandom_range(0, 19) == 0, ADDR_W'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(1, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
